// File: rtl/hack_screen_pkg.sv
// Shared constants and types for the Hack screen scan-out engine:
// 640x480@60 VGA timing, framebuffer geometry and the scan position type.
package hack_screen_pkg;

  localparam int H_VIS   = 640;
  localparam int H_FP    = 16;
  localparam int H_SYNC  = 96;
  localparam int H_BP    = 48;
  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;

  localparam int V_VIS   = 480;
  localparam int V_FP    = 10;
  localparam int V_SYNC  = 2;
  localparam int V_BP    = 33;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [15:0] SCREEN_BASE   = 16'h4000;
  localparam int          SCREEN_WORDS  = 8192;
  localparam int          WORDS_PER_ROW = 32;
  localparam int          WORD_BITS     = 16;
  localparam int          FB_AW         = $clog2(SCREEN_WORDS);

  localparam int IMG_W = WORDS_PER_ROW * WORD_BITS;
  localparam int IMG_H = SCREEN_WORDS / WORDS_PER_ROW;

  typedef logic [9:0] hcnt_t;
  typedef logic [9:0] vcnt_t;

  typedef struct packed {
    hcnt_t h;
    vcnt_t v;
  } scan_pos_t;

  // Each image row occupies 32 consecutive words, so the address is {row, word}.
  function automatic logic [FB_AW-1:0] fb_word_addr(input logic [7:0] row,
                                                    input logic [4:0] k);
    return {row, k};
  endfunction

endpackage

// File: rtl/hack_screen_scan_if.sv
// Framebuffer read port and video output bundle of the scan-out engine.
// master = scan engine side, slave = RAM / video sink side.
interface hack_screen_scan_if;
  import hack_screen_pkg::*;

  logic [FB_AW-1:0]     fb_addr;
  logic                 fb_rd;
  logic [WORD_BITS-1:0] fb_rdata;
  logic                 px;
  logic                 de;
  logic                 hsync;
  logic                 vsync;
  logic                 frame_start;

  modport master (
    output fb_addr, fb_rd, px, de, hsync, vsync, frame_start,
    input  fb_rdata
  );

  modport slave (
    input  fb_addr, fb_rd, px, de, hsync, vsync, frame_start,
    output fb_rdata
  );

endinterface

// File: rtl/hack_vga_timing.sv
// 800x525 VGA raster counters with registered hsync/vsync/de/frame_start decode.
// Decoded outputs lag the exported counter position by exactly one cycle.
module hack_vga_timing
  import hack_screen_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  output scan_pos_t o_pos,
  output logic      o_de,
  output logic      o_hsync,
  output logic      o_vsync,
  output logic      o_frame_start
);

  hcnt_t r_h;
  vcnt_t r_v;
  logic  r_de;
  logic  r_hsync;
  logic  r_vsync;
  logic  r_frame_start;

  logic  w_h_last;
  logic  w_v_last;

  assign w_h_last = (r_h == hcnt_t'(H_TOTAL - 1));
  assign w_v_last = (r_v == vcnt_t'(V_TOTAL - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_h           <= '0;
      r_v           <= '0;
      r_de          <= 1'b0;
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_frame_start <= 1'b0;
    end else begin
      // NOTE: non-blocking so the decode below sees the pre-edge counter values.
      r_h <= w_h_last ? '0 : r_h + 10'd1;
      if (w_h_last) begin
        r_v <= w_v_last ? '0 : r_v + 10'd1;
      end
      r_de          <= (r_h < hcnt_t'(H_VIS)) && (r_v < vcnt_t'(V_VIS));
      r_hsync       <= !((r_h >= hcnt_t'(H_VIS + H_FP)) &&
                         (r_h <  hcnt_t'(H_VIS + H_FP + H_SYNC)));
      r_vsync       <= !((r_v >= vcnt_t'(V_VIS + V_FP)) &&
                         (r_v <  vcnt_t'(V_VIS + V_FP + V_SYNC)));
      r_frame_start <= (r_h == '0) && (r_v == '0);
    end
  end

  assign o_pos         = '{h: r_h, v: r_v};
  assign o_de          = r_de;
  assign o_hsync       = r_hsync;
  assign o_vsync       = r_vsync;
  assign o_frame_start = r_frame_start;

endmodule

// File: rtl/hack_screen_scan.sv
// Hack screen scan-out: centres the 512x256 framebuffer in a 640x480 raster.
// Build option HACK_SCREEN_BORDER_EN paints the visible border black (px=1).
module hack_screen_scan
  import hack_screen_pkg::*;
#(
  parameter int H_OFS = 64,
  parameter int V_OFS = 112
) (
  input logic                clk,
  input logic                reset,
  hack_screen_scan_if.master bus
);

`ifdef HACK_SCREEN_BORDER_EN
  localparam logic BORDER_PX = 1'b1;
`else
  localparam logic BORDER_PX = 1'b0;
`endif

  // fb_rd is a register, so the fetch is decided one count before it appears.
  localparam int FETCH_H0 = H_OFS - 3;
  localparam int LOAD_H0  = H_OFS - 1;

  scan_pos_t w_pos;
  logic      w_de;
  logic      w_hsync;
  logic      w_vsync;
  logic      w_frame_start;

  hack_vga_timing u_timing (
    .clk           (clk),
    .reset         (reset),
    .o_pos         (w_pos),
    .o_de          (w_de),
    .o_hsync       (w_hsync),
    .o_vsync       (w_vsync),
    .o_frame_start (w_frame_start)
  );

  logic                 w_win_line;
  logic                 w_win_col;
  logic                 w_vis;
  logic [9:0]           w_fetch_off;
  logic [9:0]           w_load_off;
  logic                 w_fetch;
  logic                 w_load;
  logic [7:0]           w_row;
  logic [4:0]           w_k;

  logic [FB_AW-1:0]     r_fb_addr;
  logic                 r_fb_rd;
  logic [WORD_BITS-1:0] r_shift;
  logic                 r_px;

  assign w_win_line = (w_pos.v >= vcnt_t'(V_OFS)) &&
                      (w_pos.v <= vcnt_t'(V_OFS + IMG_H - 1));
  assign w_win_col  = (w_pos.h >= hcnt_t'(H_OFS)) &&
                      (w_pos.h <= hcnt_t'(H_OFS + IMG_W - 1));
  assign w_vis      = (w_pos.h < hcnt_t'(H_VIS)) && (w_pos.v < vcnt_t'(V_VIS));

  assign w_fetch_off = w_pos.h - hcnt_t'(FETCH_H0);
  assign w_load_off  = w_pos.h - hcnt_t'(LOAD_H0);

  // One slot every 16 counts, 32 slots per window line, never a 33rd.
  assign w_fetch = w_win_line && (w_pos.h >= hcnt_t'(FETCH_H0)) &&
                   (w_fetch_off[3:0] == 4'd0) && (w_fetch_off[9:4] < 6'd32);
  assign w_load  = w_win_line && (w_pos.h >= hcnt_t'(LOAD_H0)) &&
                   (w_load_off[3:0] == 4'd0) && (w_load_off[9:4] < 6'd32);

  assign w_row = 8'(w_pos.v - vcnt_t'(V_OFS));
  assign w_k   = w_fetch_off[8:4];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fb_addr <= '0;
      r_fb_rd   <= 1'b0;
      r_shift   <= '0;
      r_px      <= 1'b0;
    end else begin
      r_fb_rd <= w_fetch;
      if (w_fetch) begin
        r_fb_addr <= fb_word_addr(w_row, w_k);
      end
      // The reload lands on the last pixel of the previous word, so it wins over the shift.
      if (w_load) begin
        r_shift <= bus.fb_rdata;
      end else if (w_win_line && w_win_col) begin
        r_shift <= {1'b0, r_shift[WORD_BITS-1:1]};
      end
      r_px <= w_vis && ((w_win_line && w_win_col) ? r_shift[0] : BORDER_PX);
    end
  end

  assign bus.fb_addr     = r_fb_addr;
  assign bus.fb_rd       = r_fb_rd;
  assign bus.px          = r_px;
  assign bus.de          = w_de;
  assign bus.hsync       = w_hsync;
  assign bus.vsync       = w_vsync;
  assign bus.frame_start = w_frame_start;

endmodule
